// File: rtl/led_matrix_scanner_if.sv
// Frame-source / panel-driver bundle for the 16x16 bicolour LED matrix scanner.
// The brightness field exists only when BRIGHTNESS_PWM_EN is defined.
interface led_matrix_scanner_if;
   logic [15:0][15:0] Red;
   logic [15:0][15:0] Grn;
   logic              frame_valid;
`ifdef BRIGHTNESS_PWM_EN
   logic [3:0]        brightness;
`endif
   logic              ser_data_r;
   logic              ser_data_g;
   logic              ser_clk;
   logic              ser_latch;
   logic [3:0]        row_sel;
   logic              row_oe_n;
   logic              frame_done;

   // Frame source side: supplies bitmaps, observes the panel signals.
   modport master (
      output Red,
      output Grn,
      output frame_valid,
`ifdef BRIGHTNESS_PWM_EN
      output brightness,
`endif
      input  ser_data_r,
      input  ser_data_g,
      input  ser_clk,
      input  ser_latch,
      input  row_sel,
      input  row_oe_n,
      input  frame_done
   );

   modport slave (
      input  Red,
      input  Grn,
      input  frame_valid,
`ifdef BRIGHTNESS_PWM_EN
      input  brightness,
`endif
      output ser_data_r,
      output ser_data_g,
      output ser_clk,
      output ser_latch,
      output row_sel,
      output row_oe_n,
      output frame_done
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered row scanner for a 16x16 bicolour LED panel with serial column shift registers.
// Optional per-row PWM dimming is enabled by defining BRIGHTNESS_PWM_EN.
module led_matrix_scanner #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned ROW_HOLD = 64
) (
   input logic                 clk,
   input logic                 reset,
   led_matrix_scanner_if.slave bus
);

   localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DwellW = $clog2(ROW_HOLD);
   localparam int unsigned Slice  = ROW_HOLD / 16;

   typedef enum logic [1:0] {StLoad, StShift, StLatch, StDisplay} state_e;

   state_e            state_q, state_d;
   logic [15:0][15:0] red_q, grn_q;
   logic [3:0]        row_q, row_d;
   logic [3:0]        bit_q, bit_d;
   logic              phase_q, phase_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [3:0]        row_sel_q;
   logic              last_r_q, last_g_q;
   logic              done_q;
   logic              div_end, dwell_end, bit_end;
   logic              cur_r, cur_g;
   logic              oe_on;

   assign div_end   = (div_q == DivW'(CLK_DIV - 1));
   assign dwell_end = (dwell_q == DwellW'(ROW_HOLD - 1));
   assign bit_end   = phase_q && div_end;

   // Column 15 leaves first, so the shadow column index is the inverted bit count.
   assign cur_r = red_q[row_q][~bit_q];
   assign cur_g = grn_q[row_q][~bit_q];

`ifdef BRIGHTNESS_PWM_EN
   logic [3:0] bright_q;

   assign oe_on = (32'(dwell_q) < ((32'(bright_q) + 32'd1) * Slice));
`else
   assign oe_on = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:    state_d = StShift;
         StShift:   if (bit_end && (bit_q == 4'd15)) state_d = StLatch;
         StLatch:   if (div_end) state_d = StDisplay;
         StDisplay: if (dwell_end) state_d = (row_q == 4'd15) ? StLoad : StShift;
         default:   state_d = StLoad;
      endcase
   end

   always_comb begin
      row_d   = row_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      div_d   = div_q;
      dwell_d = dwell_q;
      unique case (state_q)
         StLoad: begin
            row_d   = 4'd0;
            bit_d   = 4'd0;
            phase_d = 1'b0;
            div_d   = '0;
            dwell_d = '0;
         end
         StShift: begin
            div_d = div_end ? '0 : div_q + 1'b1;
            if (div_end) begin
               phase_d = ~phase_q;
               // The bit counter wraps 15->0 exactly as SHIFT is left.
               if (phase_q) bit_d = bit_q + 4'd1;
            end
         end
         StLatch: begin
            div_d = div_end ? '0 : div_q + 1'b1;
         end
         StDisplay: begin
            dwell_d = dwell_end ? '0 : dwell_q + 1'b1;
            if (dwell_end && (row_q != 4'd15)) row_d = row_q + 4'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q   <= 4'd0;
         bit_q   <= 4'd0;
         phase_q <= 1'b0;
         div_q   <= '0;
         dwell_q <= '0;
      end else begin
         row_q   <= row_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         dwell_q <= dwell_d;
      end
   end

   // Shadow frame: the only place the inputs are sampled, so a frame never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red_q <= '0;
         grn_q <= '0;
      end else if ((state_q == StLoad) && bus.frame_valid) begin
         red_q <= bus.Red;
         grn_q <= bus.Grn;
      end
   end

`ifdef BRIGHTNESS_PWM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bright_q <= 4'hF;
      end else if ((state_q == StLoad) && bus.frame_valid) begin
         bright_q <= bus.brightness;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_sel_q <= 4'd0;
         last_r_q  <= 1'b0;
         last_g_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if ((state_q == StShift) && (state_d == StLatch)) row_sel_q <= row_q;
         if (state_q == StShift) begin
            last_r_q <= cur_r;
            last_g_q <= cur_g;
         end
         done_q <= (state_q == StDisplay) && (state_d == StLoad);
      end
   end

   always_comb begin
      bus.ser_data_r = last_r_q;
      bus.ser_data_g = last_g_q;
      bus.ser_clk    = 1'b0;
      bus.ser_latch  = 1'b0;
      bus.row_oe_n   = 1'b1;
      bus.row_sel    = row_sel_q;
      bus.frame_done = done_q;
      unique case (state_q)
         StShift: begin
            bus.ser_data_r = cur_r;
            bus.ser_data_g = cur_g;
            bus.ser_clk    = phase_q;
         end
         StLatch:   bus.ser_latch = 1'b1;
         StDisplay: bus.row_oe_n  = ~oe_on;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: frame-timeline model checked every cycle plus directed literal checks.
// Covers BRIGHTNESS_PWM_EN builds as well as the default build.
module tb_led_matrix_scanner;
   localparam int unsigned D      = 2;
   localparam int unsigned H      = 64;
   localparam int          RowP   = 32 * D + D + H;
   localparam int          FrameP = 16 * RowP + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   led_matrix_scanner_if bus ();

   led_matrix_scanner #(.CLK_DIV(D), .ROW_HOLD(H)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: position within the frame timeline and the frame it believes is displayed.
   logic [15:0][15:0] m_red, m_grn, face;
   logic [3:0]        m_bright = 4'hF;
   int                pos = 0;
   int                cur_pos = -1;
   bit                fresh = 1'b1;
   bit                done_flag = 1'b0;
   int                last_fd = -1;

   function automatic logic [9:0] expect_out(input int p);
      int r, o, b, lim;
      logic dr, dg, sc, la, oe, fd;
      logic [3:0] sel;
      dr  = m_red[15][0];
      dg  = m_grn[15][0];
      sc  = 1'b0;
      la  = 1'b0;
      oe  = 1'b1;
      fd  = 1'b0;
      sel = fresh ? 4'd0 : 4'd15;
`ifdef BRIGHTNESS_PWM_EN
      lim = (int'(m_bright) + 1) * (H / 16);
`else
      lim = H;
`endif
      if (p == 0) begin
         fd = done_flag;
      end else begin
         r = (p - 1) / RowP;
         o = (p - 1) % RowP;
         if (o < 32 * D) begin
            b  = o / (2 * D);
            dr = m_red[r][15-b];
            dg = m_grn[r][15-b];
            sc = (o % (2 * D)) >= D;
            if (r > 0) sel = 4'(r - 1);
         end else begin
            dr  = m_red[r][0];
            dg  = m_grn[r][0];
            sel = 4'(r);
            if (o < 33 * D) la = 1'b1;
            else oe = !((o - 33 * D) < lim);
         end
      end
      return {dr, dg, sc, la, sel, oe, fd};
   endfunction

   always @(negedge clk) begin
      logic [9:0] act, exp_v;
      act = {bus.ser_data_r, bus.ser_data_g, bus.ser_clk, bus.ser_latch, bus.row_sel,
             bus.row_oe_n, bus.frame_done};
      if (reset) begin
         exp_v     = 10'b00_0000_0010;
         pos       = 0;
         cur_pos   = -1;
         fresh     = 1'b1;
         done_flag = 1'b0;
         m_red     = '0;
         m_grn     = '0;
         m_bright  = 4'hF;
         last_fd   = -1;
      end else begin
         exp_v   = expect_out(pos);
         cur_pos = pos;
         if ((pos == 0) && bus.frame_valid) begin
            m_red = bus.Red;
            m_grn = bus.Grn;
`ifdef BRIGHTNESS_PWM_EN
            m_bright = bus.brightness;
`endif
         end
         if (pos == 0) done_flag = 1'b0;
         pos++;
         if (pos == FrameP) begin
            pos       = 0;
            fresh     = 1'b0;
            done_flag = 1'b1;
         end
         if (bus.frame_done) begin
            if (last_fd >= 0) begin
               total++;
               if (cyc - last_fd != FrameP) begin
                  bad++;
                  $display("FAIL frame_done_period got %0d want %0d", cyc - last_fd, FrameP);
               end
            end
            last_fd = cyc;
         end
      end
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL cycle_outputs cyc=%0d pos=%0d got %b want %b", cyc, cur_pos, act, exp_v);
      end
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_pos(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * FrameP; i++) begin
         if (cur_pos == target) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) check("wait_pos_timeout", 0, 1);
   endtask

   // Captures one row: bits at each ser_clk rise, latch cycles, enabled cycles, row_sel errors.
   task automatic grab(input int row, output logic [15:0] g, output logic [15:0] rd,
                       output int edges, output int first_edge, output int lat,
                       output int oe_lo, output int sel_bad);
      bit ok;
      logic prev;
      g = '0; rd = '0; edges = 0; first_edge = -1; lat = 0; oe_lo = 0; sel_bad = 0;
      prev = 1'b0;
      wait_pos(1 + row * RowP, ok);
      if (ok) begin
         for (int i = 0; i < RowP; i++) begin
            if (bus.ser_clk && !prev) begin
               g  = {g[14:0], bus.ser_data_g};
               rd = {rd[14:0], bus.ser_data_r};
               if (edges == 0) first_edge = i;
               edges++;
            end
            prev = bus.ser_clk;
            if (bus.ser_latch) lat++;
            if (!bus.row_oe_n) begin
               oe_lo++;
               if (bus.row_sel != 4'(row)) sel_bad++;
            end
            step();
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] g, rd, g2a, g10a;
      int e, fe, l, o, sb, lat_seen, sel_seen;
      bit ok;
      face      = '0;
      face[0]   = 16'hFFFF;
      face[2]   = 16'h000D;
      face[7]   = 16'h8001;
      face[10]  = 16'h3C3C;
      face[15]  = 16'h0001;
      bus.Red   = '0;
      bus.Grn   = face;
      bus.frame_valid = 1'b1;
`ifdef BRIGHTNESS_PWM_EN
      bus.brightness = 4'hF;
`endif
      reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check("reset_outputs", {bus.ser_data_r, bus.ser_data_g, bus.ser_clk, bus.ser_latch,
                              bus.row_sel, bus.row_oe_n, bus.frame_done}, 10'b00_0000_0010);
      @(posedge clk); #2;
      reset = 1'b0;

      // Frame 1: game-over face.
      grab(0, g, rd, e, fe, l, o, sb);
      check("row0_green", g, 16'hFFFF);
      check("row0_red", rd, 16'h0000);
      check("row0_edges", e, 16);
      check("first_sclk_rise", 1 + fe, 1 + D);
      grab(2, g, rd, e, fe, l, o, sb);
      check("row2_green", g, 16'h000D);
      check("row2_red", rd, 16'h0000);
      check("row2_latch_cycles", l, D);
      check("row2_oe_cycles", o, H);
      check("row2_sel_errors", sb, 0);
      wait_pos(1 + 5 * RowP + 40, ok);
      bus.Grn = '0;
      grab(10, g, rd, e, fe, l, o, sb);
      check("row10_old_frame", g, 16'h3C3C);
      grab(15, g, rd, e, fe, l, o, sb);
      check("row15_old_frame", g, 16'h0001);

      // Frame 2: zeros were loaded.
      grab(0, g, rd, e, fe, l, o, sb);
      check("f2_row0_off", g, 16'h0000);
      grab(10, g, rd, e, fe, l, o, sb);
      check("f2_row10_off", g, 16'h0000);
      bus.Grn = face;

      // Frame 3 loads the face; frame 4 must repeat it with frame_valid low.
      grab(2, g2a, rd, e, fe, l, o, sb);
      grab(10, g10a, rd, e, fe, l, o, sb);
      check("f3_row10", g10a, 16'h3C3C);
      bus.frame_valid = 1'b0;
      bus.Grn = '0;
      grab(2, g, rd, e, fe, l, o, sb);
      check("f4_row2_repeat", g, g2a);
      check("f4_row2_literal", g, 16'h000D);
      grab(10, g, rd, e, fe, l, o, sb);
      check("f4_row10_repeat", g, 16'h3C3C);

      // Reset during SHIFT of row 7, bit 9.
      wait_pos(1 + 7 * RowP + 9 * 2 * D, ok);
      reset = 1'b1;
      #1;
      check("midop_reset_outputs", {bus.ser_data_r, bus.ser_data_g, bus.ser_clk, bus.ser_latch,
                                    bus.row_sel, bus.row_oe_n, bus.frame_done}, 10'b00_0000_0010);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      step();
      check("restart_pos", cur_pos, 0);
      lat_seen = 0;
      sel_seen = 0;
      for (int i = 0; i < 1 + 32 * D; i++) begin
         if (bus.ser_latch) lat_seen++;
         if (bus.row_sel != 4'd0) sel_seen++;
         step();
      end
      check("restart_no_partial_latch", lat_seen, 0);
      check("restart_row_sel", sel_seen, 0);
      check("restart_latch_row0", {bus.ser_latch, bus.row_sel}, 5'b1_0000);

      // Dimmed frame.
      bus.frame_valid = 1'b1;
      bus.Grn = face;
`ifdef BRIGHTNESS_PWM_EN
      bus.brightness = 4'd3;
`endif
      wait_pos(0, ok);
      grab(3, g, rd, e, fe, l, o, sb);
`ifdef BRIGHTNESS_PWM_EN
      check("pwm_oe_cycles", o, 16);
`else
      check("full_oe_cycles", o, H);
`endif
      check("row3_latch_cycles", l, D);
      grab(4, g, rd, e, fe, l, o, sb);
      check("row4_edges", e, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Downstream display stage for the 16x16 bicolour LED matrix.
- Consumes full-frame Red/Grn bitmaps from the frame sources (game playfield, game-over face), double-buffers them at frame boundaries and row-scans the panel.
- Each row's column data goes out serially to the column shift registers. The block then latches the data, selects the row and enables the drivers for a fixed dwell time.

Parameters:
- CLK_DIV, 2: system clocks per ser_clk phase (high or low); must be >=1.
- ROW_HOLD, 64: system clocks a row stays displayed; must be a multiple of 16 and >=16.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- Red, input, [15:0][15:0]: red frame; Red[r][c], 1 = lit.
- Grn, input, [15:0][15:0]: green frame; same layout as Red.
- frame_valid, input, 1: Red/Grn hold a complete frame; sampled only in LOAD.
- ser_data_r, output, 1: serial red column bit.
- ser_data_g, output, 1: serial green column bit.
- ser_clk, output, 1: shift clock; external registers shift on its rising edge.
- ser_latch, output, 1: storage-register latch strobe, active high.
- row_sel, output, 4: index of the row being driven.
- row_oe_n, output, 1: row/column driver enable, active low (1 = blanked).
- frame_done, output, 1: one-cycle pulse after row 15's dwell completes.

Behaviour:
- Reset state: ser_data_r=0, ser_data_g=0, ser_clk=0, ser_latch=0, row_sel=0, row_oe_n=1, frame_done=0. Shadow frame is all zeros, row counter is 0, state is LOAD.
- Reset asserted mid-operation returns everything to the reset state within the same cycle; the next frame starts at row 0.
- FSM: LOAD -> SHIFT -> LATCH -> DISPLAY -> (SHIFT for next row | LOAD after row 15).
- LOAD, 1 cycle:
  - If frame_valid=1, copy Red/Grn into shadow registers; otherwise the shadow is unchanged.
  - Row counter = 0. Go to SHIFT.
  - Inputs are never sampled outside LOAD, so a displayed frame never tears.
- SHIFT, 16 bits x 2*CLK_DIV cycles:
  - Bits go MSB first: column 15 first, column 0 last, from shadow row[counter].
  - For each bit, ser_data_r/g are set at the start of the low phase, held CLK_DIV cycles with ser_clk=0, then CLK_DIV cycles with ser_clk=1.
  - Data is stable across every ser_clk rising edge. Exactly 16 rising edges per row.
  - row_oe_n=1 throughout. ser_clk returns to 0 on exit.
- LATCH, CLK_DIV cycles:
  - ser_latch=1 and row_oe_n=1.
  - row_sel is updated to the row counter on the first LATCH cycle.
- DISPLAY, ROW_HOLD cycles:
  - row_oe_n=0 and ser_latch=0; ser_data holds the last bit.
  - At the end, if counter=15: pulse frame_done for one cycle (the first LOAD cycle) and go to LOAD. Otherwise increment the counter and go to SHIFT.
- Timing: row period = 32*CLK_DIV + CLK_DIV + ROW_HOLD (130 at defaults). Frame period = 16*row period + 1 (2081).
- Counter widths: the bit counter is 4 bits and wraps 15->0 only on leaving SHIFT. The row counter is 4 bits. Dwell and divide counters are sized by $clog2 of their parameter.
- frame_valid low at LOAD: the previous frame is redisplayed. After reset with no valid frame, the panel scans all-off.

Optional Feature:
- Macro BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input port brightness, 4 bits, sampled in LOAD with the frame.
  - During DISPLAY, row_oe_n=0 only while dwell count < (brightness+1)*(ROW_HOLD/16), then 1 for the rest of the dwell.
  - The row period is unchanged. brightness=15 gives full on.
- When undefined: no brightness port; row_oe_n=0 for the whole of DISPLAY.

Test Plan:
- Reset hold 5 cycles, release -> all outputs at reset values during reset. First ser_clk rise at cycle 1+CLK_DIV after LOAD. row_sel=0.
- Drive the game-over face on Grn (row0=16'hFFFF, row2=16'h000D), Red=0, frame_valid=1:
  - Row 0: 16 green bits all 1.
  - Row 2: green bits in order 0000000000001101.
  - Red bits all 0.
  - ser_latch high 2 cycles, then row_oe_n low 64 cycles with row_sel=2.
- Change Grn to all zeros mid-frame (during row 5) -> rows 6..15 still show the old frame. The next frame shows all-off. frame_done pulses exactly once per 2081 cycles.
- Hold frame_valid=0 at LOAD after a loaded frame -> the identical bitstream repeats for the following frame.
- Assert reset during SHIFT of row 7, bit 9 -> outputs return to reset values the same cycle. After release the scan restarts at LOAD/row 0 with no partial ser_latch.
- With BRIGHTNESS_PWM_EN, brightness=3 -> row_oe_n low for exactly 16 of 64 DISPLAY cycles per row. Row period remains 130 cycles.
